ram_bank: RTL and testbench

RAM_BANK -- requirements
Module: ram_bank

---
 rtl/ram_bank_pkg.sv | 14 +
 rtl/ram_bank_if.sv | 31 +++
 rtl/ram_bank_clear_seq.sv | 36 +++
 rtl/ram_bank.sv | 71 +++++++
 tb/tb_ram_bank.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/ram_bank_pkg.sv
// rtl/ram_bank_pkg.sv - shared word width, clear sequencer state encoding and sizing helper for ram_bank
package ram_bank_pkg;

  localparam int HACK_WORD_W = 16;

  localparam int STATE_W = 1;
  localparam logic [STATE_W-1:0] ST_CLEAR = 1'b0;
  localparam logic [STATE_W-1:0] ST_IDLE  = 1'b1;

  function automatic int depth_of(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/ram_bank_if.sv
// rtl/ram_bank_if.sv - read/write port bundle of ram_bank; master drives in/load/address, slave returns out/busy
interface ram_bank_if
  import ram_bank_pkg::*;
#(
  parameter int WIDTH  = HACK_WORD_W,
  parameter int ADDR_W = 3
);

  logic [WIDTH-1:0]  in;
  logic              load;
  logic [ADDR_W-1:0] address;
  logic [WIDTH-1:0]  out;
  logic              busy;

  modport master (
    output in,
    output load,
    output address,
    input  out,
    input  busy
  );

  modport slave (
    input  in,
    input  load,
    input  address,
    output out,
    output busy
  );

endinterface

// File: rtl/ram_bank_clear_seq.sv
// rtl/ram_bank_clear_seq.sv - post-reset sweep that zeroes every word; built only with RAM_BANK_CLEAR_EN
`ifdef RAM_BANK_CLEAR_EN
module ram_bank_clear_seq
  import ram_bank_pkg::*;
#(
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  output logic              busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  logic [STATE_W-1:0] r_state;
  logic [ADDR_W-1:0]  r_ptr;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_CLEAR;
      r_ptr   <= '0;
    end else if (r_state == ST_CLEAR) begin
      r_ptr <= r_ptr + 1'b1;
      if (r_ptr == {ADDR_W{1'b1}}) begin
        r_state <= ST_IDLE;
      end
    end
  end

  assign busy     = (r_state == ST_CLEAR);
  // a reset landing mid-sweep must not also write the word under ptr
  assign clr_we   = busy & ~reset;
  assign clr_addr = r_ptr;

endmodule
`endif

// File: rtl/ram_bank.sv
// rtl/ram_bank.sv - DEPTH x WIDTH RAM with combinational read and clocked write
// RAM_BANK_CLEAR_EN adds a post-reset zeroing sweep that owns the write port while busy.
module ram_bank
  import ram_bank_pkg::*;
#(
  parameter int WIDTH  = HACK_WORD_W,
  parameter int ADDR_W = 3
) (
  input  logic      clk,
  input  logic      reset,
  ram_bank_if.slave bus
);

  localparam int DEPTH = depth_of(ADDR_W);

  logic [WIDTH-1:0]  r_mem [DEPTH];

  logic              w_busy;
  logic              w_we;
  logic [ADDR_W-1:0] w_waddr;
  logic [WIDTH-1:0]  w_wdata;

`ifdef RAM_BANK_CLEAR_EN
  logic              w_clr_we;
  logic [ADDR_W-1:0] w_clr_addr;

  ram_bank_clear_seq #(
    .ADDR_W (ADDR_W)
  ) u_clear_seq (
    .clk      (clk),
    .reset    (reset),
    .busy     (w_busy),
    .clr_we   (w_clr_we),
    .clr_addr (w_clr_addr)
  );

  // the sweep owns the write port while busy; user loads are dropped, not queued
  always_comb begin
    w_we    = 1'b0;
    w_waddr = bus.address;
    w_wdata = bus.in;
    if (w_busy) begin
      w_we    = w_clr_we;
      w_waddr = w_clr_addr;
      w_wdata = '0;
    end else if (!reset) begin
      w_we = bus.load;
    end
  end

  assign bus.out = w_busy ? '0 : r_mem[bus.address];
`else
  logic w_unused_reset;

  assign w_unused_reset = reset;
  assign w_busy         = 1'b0;
  assign w_we           = bus.load;
  assign w_waddr        = bus.address;
  assign w_wdata        = bus.in;
  assign bus.out        = r_mem[bus.address];
`endif

  assign bus.busy = w_busy;

  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem[w_waddr] <= w_wdata;
    end
  end

endmodule

// File: tb/tb_ram_bank.sv
// tb/tb_ram_bank.sv - scoreboard bench for ram_bank (WIDTH=16, ADDR_W=3); test set follows RAM_BANK_CLEAR_EN
module tb_ram_bank;

  logic clk;
  logic reset;

  ram_bank_if #(.WIDTH(16), .ADDR_W(3)) bus ();

  ram_bank #(
    .WIDTH  (16),
    .ADDR_W (3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  string       q_tag  [$];
  logic        q_busy [$];
  logic        q_chk  [$];
  logic [15:0] q_out  [$];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic expect_now(input string tag, input logic b, input logic chk, input logic [15:0] o);
    q_tag.push_back(tag);
    q_busy.push_back(b);
    q_chk.push_back(chk);
    q_out.push_back(o);
  endtask

  // monitor: away from the active edge, compare every expectation issued this cycle
  always @(negedge clk) begin
    while (q_tag.size() > 0) begin
      string       t;
      logic        eb;
      logic        ec;
      logic [15:0] eo;
      t  = q_tag.pop_front();
      eb = q_busy.pop_front();
      ec = q_chk.pop_front();
      eo = q_out.pop_front();
      n_tests++;
      if ((bus.busy !== eb) || (ec && (bus.out !== eo))) begin
        n_fail++;
        $display("FAIL %s: got busy=%b out=0x%04h, expected busy=%b out=0x%04h%s",
                 t, bus.busy, bus.out, eb, eo, ec ? "" : " (out not checked)");
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    bus.address = a;
    bus.in      = d;
    bus.load    = 1'b1;
    step();
    bus.load    = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [2:0] a, input logic [15:0] exp_o);
    bus.address = a;
    bus.load    = 1'b0;
    expect_now(tag, 1'b0, 1'b1, exp_o);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion well before 200000");
    $fatal(1);
  end

  initial begin
    reset       = 1'b0;
    bus.in      = '0;
    bus.load    = 1'b0;
    bus.address = '0;
    #1;
    reset = 1'b1;
`ifdef RAM_BANK_CLEAR_EN
    step();
    reset = 1'b0;
    // loads during the sweep must be dropped; busy for 8 cycles with out forced to 0
    for (int c = 0; c < 8; c++) begin
      bus.address = c[2:0];
      bus.in      = 16'hFFFF;
      bus.load    = 1'b1;
      expect_now($sformatf("sweep_c%0d", c), 1'b1, 1'b1, 16'h0000);
      step();
    end
    bus.load = 1'b0;
    for (int a = 0; a < 8; a++) begin
      rd($sformatf("cleared_a%0d", a), a[2:0], 16'h0000);
    end

    wr(3'd5, 16'h1234);
    rd("wr_readback_a5", 3'd5, 16'h1234);
    rd("neighbour_a4", 3'd4, 16'h0000);

    bus.address = 3'd2;
    bus.in      = 16'hBEEF;
    bus.load    = 1'b1;
    expect_now("pre_edge_old_a2", 1'b0, 1'b1, 16'h0000);
    step();
    rd("post_edge_new_a2", 3'd2, 16'hBEEF);

    bus.in = 16'h5555;
    rd("load0_hold_a2", 3'd2, 16'hBEEF);

    for (int a = 0; a < 8; a++) begin
      wr(a[2:0], 16'hAAAA);
    end
    rd("preload_a6", 3'd6, 16'hAAAA);

    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      bus.address = 3'd7;
      expect_now($sformatf("sweep2_c%0d", c), 1'b1, 1'b1, 16'h0000);
      step();
    end
    reset       = 1'b1;
    bus.address = 3'd7;
    expect_now("sweep2_c3_reset", 1'b1, 1'b1, 16'h0000);
    step();
    reset = 1'b0;
    for (int c = 0; c < 8; c++) begin
      bus.address = c[2:0];
      expect_now($sformatf("restart_c%0d", c), 1'b1, 1'b1, 16'h0000);
      step();
    end
    for (int a = 0; a < 8; a++) begin
      rd($sformatf("restart_clr_a%0d", a), a[2:0], 16'h0000);
    end
`else
    expect_now("rst_busy", 1'b0, 1'b0, 16'h0000);
    step();
    reset       = 1'b0;
    bus.address = 3'd7;
    bus.in      = 16'h00FF;
    bus.load    = 1'b1;
    expect_now("first_edge_busy", 1'b0, 1'b0, 16'h0000);
    step();
    bus.load = 1'b0;
    rd("first_edge_wr_a7", 3'd7, 16'h00FF);

    wr(3'd2, 16'h0000);
    bus.address = 3'd2;
    bus.in      = 16'hBEEF;
    bus.load    = 1'b1;
    expect_now("pre_edge_old_a2", 1'b0, 1'b1, 16'h0000);
    step();
    rd("post_edge_new_a2", 3'd2, 16'hBEEF);

    wr(3'd5, 16'h1234);
    bus.in = 16'hFFFF;
    rd("wr_readback_a5", 3'd5, 16'h1234);
    rd("load0_hold_a2", 3'd2, 16'hBEEF);

    reset       = 1'b1;
    bus.address = 3'd7;
    expect_now("reset_no_effect_a7", 1'b0, 1'b1, 16'h00FF);
    step();
    reset = 1'b0;
    rd("after_reset_a7", 3'd7, 16'h00FF);
    rd("after_reset_a5", 3'd5, 16'h1234);

    wr(3'd0, 16'h0000);
    wr(3'd1, 16'h1111);
    wr(3'd3, 16'h3333);
    wr(3'd4, 16'h4444);
    wr(3'd6, 16'h6666);
    rd("pattern_a0", 3'd0, 16'h0000);
    rd("pattern_a1", 3'd1, 16'h1111);
    rd("pattern_a3", 3'd3, 16'h3333);
    rd("pattern_a4", 3'd4, 16'h4444);
    rd("pattern_a6", 3'd6, 16'h6666);
    rd("pattern_a7", 3'd7, 16'h00FF);
`endif
    step();
    if (q_tag.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d expectations left, expected 0", q_tag.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
